dram_ctrl: RTL and testbench
============================

DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL provide ports: dc_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL provide dc_rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL provide req_valid  in  1  core presents an access; req_ready  out  1  controller accepts.
REQ-004 SHALL provide req_we  in  1  store=1 / load=0; req_size  in  2  access size; req_addr  in  32  byte address; req_wdata  in  32  store data in low bits.
REQ-005 SHALL provide resp_valid  out  1  one-cycle completion pulse; resp_err  out  1  misalignment/illegal-size flag; resp_rdata  out  32  load word, lane-shifted to bit 0.
REQ-006 SHALL provide dram_addr  out  14  word index; dram_we  out  1  write strobe; dram_wdata  out  32  write word; dram_rdata  in  32  synchronous-read data, valid one cycle after dram_addr.

Function
REQ-007 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-008 SHALL latch we/size/addr/wdata at acceptance; later req_* changes have no effect until the next IDLE.
REQ-009 SHALL implement states IDLE, RD, WAIT, WR, RESP.
REQ-010 SHALL transition from IDLE on acceptance as follows: illegal → RESP; load or sub-word store → RD; word store → WR.
REQ-011 SHALL in RD drive dram_addr=addr[15:2], dram_we=0, then go to WAIT.
REQ-012 SHALL in WAIT sample dram_rdata; a load registers resp_rdata and goes to RESP; a sub-word store registers the merged word and goes to WR.
REQ-013 SHALL in WR assert dram_we=1 for exactly one cycle with dram_addr=addr[15:2], then go to RESP.
REQ-014 SHALL in RESP assert resp_valid=1 for exactly one cycle, then go to IDLE with no back-to-back acceptance in that cycle.
REQ-015 SHALL give the following latency, counted from the acceptance-edge cycle T to the resp_valid cycle: load T+3, word store T+2, byte/half store T+4, illegal T+1.
REQ-016 SHALL return load data as resp_rdata = dram_rdata >> (8*addr[1:0]), zero-filled; byte/half truncation is left to the register file.
REQ-017 SHALL build sub-word store merges as follows: a byte replaces lane addr[1:0] with wdata[7:0]; a half replaces lanes addr[1]*2..+1 with wdata[15:0]; all other bytes are preserved from dram_rdata.
REQ-018 SHALL treat the following as illegal: half with addr[0]=1, word with addr[1:0]!=0, and size=11. An illegal request sets resp_err=1, performs no DRAM access and leaves resp_rdata unchanged.
REQ-019 SHALL hold resp_err at 0 on every legal response.
REQ-020 SHALL hold dram_we at 0 in every state other than WR.
REQ-021 SHALL ignore addr[31:16]; addresses wrap modulo 64 KiB.

Reset
REQ-022 SHALL on dc_rst=1 immediately force state=IDLE and the outputs as follows, regardless of clock: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dram_we=0, dram_addr=0, dram_wdata=0.
REQ-023 SHALL drop an in-flight access on reset with no response. A store not yet in WR SHALL never reach DRAM.
REQ-024 SHALL accept a new request at the first rising edge after dc_rst deasserts.

Structure
REQ-025 SHALL take size encodings SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10 and the state encodings from the shared defines header, alongside the existing WB_SEL/RF_SEL constants.
REQ-026 SHALL isolate lane shift and merge in one combinational sub-module, dram_lane_merge (inputs: rdata, wdata, size, offset; outputs: load_shifted, store_merged).

Verification
REQ-027 SHALL verify a word store: mem[0x10>>2]=0; store word 0xDEADBEEF at 0x10 → dram_we in T+1 only, word 4 = 0xDEADBEEF, resp_valid at T+2, resp_err=0.
REQ-028 SHALL verify a byte store: word 4=0xDEADBEEF; store byte 0x55 at 0x12 → RD/WAIT/WR sequence, word 4 = 0xDE55BEEF, resp_valid at T+4.
REQ-029 SHALL verify a half load: word 4=0xDE55BEEF; load half at 0x12 → resp_rdata=0x0000DE55 at T+3; a byte load at 0x13 → 0x000000DE.
REQ-030 SHALL verify misalignment: load word at 0x11 → resp_valid and resp_err at T+1, dram_we never asserted, resp_rdata unchanged; size=11 behaves identically.
REQ-031 SHALL verify reset mid-store: byte store accepted, dc_rst pulsed during WAIT → dram_we stays 0, no resp_valid, memory word unchanged, req_ready=1 immediately.
REQ-032 SHALL verify the handshake: req_valid held high across two requests → second accepted only after RESP (req_ready low T+1..T+3 for load), both responses in order with correct data.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared defines for the data-memory controller.
// Size/state encodings sit alongside the writeback and regfile selects.
package dram_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic RF_SEL_RS1 = 1'b0;
  localparam logic RF_SEL_RS2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic is_illegal(
    input logic [1:0] size,
    input logic [1:0] off
  );
    is_illegal = (size == 2'b11)
      || (size == SZ_HALF && off[0])
      || (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/dram_ctrl_if.sv
// Core-side request/response bus of the data-memory controller.
// master = core, slave = controller.
interface dram_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_size,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_err, resp_rdata
  );

endinterface

// File: rtl/dram_lane_merge.sv
// Byte-lane alignment: load shift to bit 0 and
// read-modify-write merge for sub-word stores.
module dram_lane_merge
  import dram_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] load_shifted,
  output logic [31:0] store_merged
);

  assign load_shifted = rdata >> {offset, 3'b000};

  always_comb begin
    store_merged = rdata;
    case (size)
      SZ_BYTE:
        store_merged[{offset, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF:
        store_merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default:
        store_merged = wdata;
    endcase
  end

endmodule

// File: rtl/dram_ctrl.sv
// Data-memory controller: one access at a time over a
// synchronous-read word RAM, with RMW for sub-word stores.
module dram_ctrl
  import dram_ctrl_pkg::*;
(
  input  logic        dc_clk,
  input  logic        dc_rst,
  dram_ctrl_if.slave  bus,
  output logic [13:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata
);

  state_t      state;
  state_t      state_nx;
  logic        we_q;
  logic [1:0]  size_q;
  logic [15:0] addr_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] wr_q;
  logic        accept;
  logic        illegal;
  logic [31:0] load_shifted;
  logic [31:0] store_merged;

  // upper address bits are outside the 64 KiB window
  logic unused_hi;
  assign unused_hi = ^bus.req_addr[31:16];

  assign accept  = bus.req_valid && state == ST_IDLE;
  assign illegal = is_illegal(bus.req_size, bus.req_addr[1:0]);

  dram_lane_merge u_merge (
    .rdata        (dram_rdata),
    .wdata        (wr_q),
    .size         (size_q),
    .offset       (addr_q[1:0]),
    .load_shifted (load_shifted),
    .store_merged (store_merged)
  );

  always_ff @(posedge dc_clk or posedge dc_rst) begin
    if (dc_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (accept) begin
          if (illegal)
            state_nx = ST_RESP;
          else if (!bus.req_we || bus.req_size != SZ_WORD)
            state_nx = ST_RD;
          else
            state_nx = ST_WR;
        end
      ST_RD:   state_nx = ST_WAIT;
      ST_WAIT: state_nx = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // wr_q holds the store data until WAIT, then the merged word
  always_ff @(posedge dc_clk or posedge dc_rst) begin
    if (dc_rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wr_q    <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr[15:0];
      err_q   <= illegal;
      wr_q    <= bus.req_wdata;
    end else if (state == ST_WAIT) begin
      if (we_q) wr_q    <= store_merged;
      else      rdata_q <= load_shifted;
    end
  end

  always_comb begin
    bus.req_ready  = state == ST_IDLE;
    bus.resp_valid = state == ST_RESP;
    bus.resp_err   = state == ST_RESP && err_q;
    bus.resp_rdata = rdata_q;
    dram_we        = state == ST_WR;
    dram_addr      = addr_q[15:2];
    dram_wdata     = wr_q;
  end

endmodule

// File: tb/tb_dram_ctrl.sv
// Scoreboard bench for dram_ctrl: reference model predicts
// responses and DRAM writes; a monitor checks them as they appear.
module tb_dram_ctrl;

  logic        dc_clk;
  logic        dc_rst;
  logic [13:0] dram_addr;
  logic        dram_we;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;

  dram_ctrl_if bus ();

  dram_ctrl dut (
    .dc_clk     (dc_clk),
    .dc_rst     (dc_rst),
    .bus        (bus),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata)
  );

  initial dc_clk = 1'b0;
  always #5 dc_clk = ~dc_clk;

  logic [31:0] mem [16384] = '{default: 32'h0};
  logic [31:0] ref_mem [16384] = '{default: 32'h0};

  always @(posedge dc_clk) begin
    if (dram_we) mem[dram_addr] <= dram_wdata;
    dram_rdata <= mem[dram_addr];
  end

  int cyc = 0;
  always @(posedge dc_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          cyc;
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    n_tot++;
    $display("FAIL %s: got event expected none/timely", nm);
  endtask

  always @(negedge dc_clk) begin
    if (!dc_rst) begin
      if (dram_we) begin
        if (wq.size() == 0) fail("dram_we_unexpected");
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_cycle", cyc, w.cyc);
          chk("wr_addr", {18'h0, dram_addr}, {18'h0, w.a});
          chk("wr_data", dram_wdata, w.d);
        end
      end
      if (bus.resp_valid) begin
        if (rq.size() == 0) fail("resp_unexpected");
        else begin
          resp_t r;
          r = rq.pop_front();
          chk("resp_cycle", cyc, r.cyc);
          chk("resp_err", {31'h0, bus.resp_err}, {31'h0, r.err});
          chk("resp_rdata", bus.resp_rdata, r.rdata);
        end
      end
    end
  end

  // reference: spec rules on a word array, no FSM modelling
  task automatic predict(
    input logic        we,
    input logic [1:0]  size,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input int          t
  );
    logic [1:0]  off;
    logic [13:0] idx;
    logic [31:0] w;
    logic        ill;
    off = addr[1:0];
    idx = addr[15:2];
    ill = size == 2'b11 || (size == 2'b01 && off[0])
      || (size == 2'b10 && off != 2'b00);
    w = ref_mem[idx];
    if (ill) begin
      rq.push_back('{t + 1, 1'b1, last_rd});
    end else if (!we) begin
      last_rd = w >> (8 * off);
      rq.push_back('{t + 3, 1'b0, last_rd});
    end else if (size == 2'b10) begin
      ref_mem[idx] = wdata;
      wq.push_back('{t + 1, idx, wdata});
      rq.push_back('{t + 2, 1'b0, last_rd});
    end else begin
      if (size == 2'b00) w[8 * off +: 8] = wdata[7:0];
      else w[16 * off[1] +: 16] = wdata[15:0];
      ref_mem[idx] = w;
      wq.push_back('{t + 3, idx, w});
      rq.push_back('{t + 4, 1'b0, last_rd});
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic do_req(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  bit          push,
    output int          t
  );
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge dc_clk);
      n++;
    end
    if (n >= 20) fail("accept_timeout");
    t = cyc;
    if (push) predict(we, size, addr, wdata, t);
    @(negedge dc_clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge dc_clk);
      n++;
    end
    if (n >= 50) fail("drain_timeout");
    @(negedge dc_clk);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    chk({nm, "_rvalid"}, {31'h0, bus.resp_valid}, 32'h0);
    chk({nm, "_rerr"}, {31'h0, bus.resp_err}, 32'h0);
    chk({nm, "_rdata"}, bus.resp_rdata, 32'h0);
    chk({nm, "_we"}, {31'h0, dram_we}, 32'h0);
    chk({nm, "_addr"}, {18'h0, dram_addr}, 32'h0);
    chk({nm, "_wdata"}, dram_wdata, 32'h0);
  endtask

  initial begin
    int t;
    int t2;
    logic [31:0] r;
    logic [31:0] a;
    dc_rst        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    #1;
    chk_idle_outputs("reset");
    repeat (3) @(negedge dc_clk);
    dc_rst = 1'b0;

    do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b1, t);
    bus.req_valid = 1'b0;
    drain();
    chk("mem_word_store", mem[4], 32'hDEADBEEF);

    do_req(1'b1, 2'b00, 32'h12, 32'h55, 1'b1, t);
    bus.req_valid = 1'b0;
    drain();
    chk("mem_byte_store", mem[4], 32'hDE55BEEF);

    do_req(1'b0, 2'b01, 32'h12, 32'h0, 1'b1, t);
    do_req(1'b0, 2'b00, 32'h13, 32'h0, 1'b1, t);
    bus.req_valid = 1'b0;
    drain();
    chk("byte_load_data", bus.resp_rdata, 32'h000000DE);

    do_req(1'b0, 2'b10, 32'h11, 32'h0, 1'b1, t);
    do_req(1'b0, 2'b11, 32'h10, 32'h0, 1'b1, t);
    do_req(1'b1, 2'b01, 32'h13, 32'h1234, 1'b1, t);
    bus.req_valid = 1'b0;
    drain();
    chk("illegal_rdata_kept", bus.resp_rdata, 32'h000000DE);

    do_req(1'b0, 2'b10, 32'h10, 32'h0, 1'b1, t);
    do_req(1'b1, 2'b10, 32'h14, 32'hCAFEF00D, 1'b1, t2);
    bus.req_valid = 1'b0;
    chk("b2b_accept_gap", t2 - t, 4);
    drain();

    for (int i = 0; i < 200; i++) begin
      r = $urandom;
      a = {r[31:16], 10'h0, r[5:0]};
      do_req(r[6], r[8:7], a, $urandom, 1'b1, t);
      if (r[9]) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge dc_clk);
      end
    end
    bus.req_valid = 1'b0;
    drain();

    // byte store aborted by reset while waiting on the read
    do_req(1'b1, 2'b00, 32'h20, 32'hA5, 1'b0, t);
    @(negedge dc_clk);
    dc_rst = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    last_rd = 32'h0;
    @(negedge dc_clk);
    dc_rst = 1'b0;
    t2 = cyc;
    do_req(1'b0, 2'b10, 32'h20, 32'h0, 1'b1, t);
    bus.req_valid = 1'b0;
    chk("post_reset_accept", t, t2);
    drain();

    for (int i = 0; i < 16; i++)
      chk($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
